// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB3 master FSM.
// The wait-state timeout (enabled by APB_TIMEOUT_EN) uses TIMEOUT_CYCLES/TO_CNT_W.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_t;

  localparam int TIMEOUT_CYCLES = 1024;
  localparam int TO_CNT_W       = 16;

  // Callers zero-extend narrower select vectors; supports up to 32 slaves.
  function automatic logic onehot_ok(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; flags expiry on the TIMEOUT_CYCLES-th ACCESS cycle.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_timeout_cnt
  import apb_master_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [TO_CNT_W-1:0] cnt;

  assign expired = run && (cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + TO_CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb_master_fsm.sv
// APB3 master: turns a single level-style request into a SETUP/ACCESS transfer.
// Optional ACCESS wait-state timeout under macro APB_TIMEOUT_EN.
module apb_master_fsm
  import apb_master_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int NUM_SLAVES = 4
) (
  input  logic                  m_apb_pclk_i,
  input  logic                  m_apb_presetn_i,
  input  logic [AW-1:0]         read_write_addr_i,
  input  logic [NUM_SLAVES-1:0] read_write_sel_i,
  input  logic                  write_en_i,
  input  logic [DW-1:0]         write_data_i,
  input  logic                  read_en_i,
  output logic [DW-1:0]         read_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [AW-1:0]         m_apb_paddr_o,
  output logic [NUM_SLAVES-1:0] m_apb_psel_o,
  output logic                  m_apb_penable_o,
  output logic                  m_apb_pwrite_o,
  output logic [DW-1:0]         m_apb_pwdata_o,
  input  logic                  m_apb_pready_i,
  input  logic [DW-1:0]         m_apb_prdata_i,
  input  logic                  m_apb_pslverr_i
);

  apb_state_t state;
  logic       timeout;

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt u_timeout (
    .clk     (m_apb_pclk_i),
    .rst_n   (m_apb_presetn_i),
    .clear   (state == SETUP),
    .run     (state == ACCESS),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge m_apb_pclk_i or negedge m_apb_presetn_i) begin
    if (!m_apb_presetn_i) begin
      state           <= IDLE;
      read_data_o     <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      m_apb_paddr_o   <= '0;
      m_apb_psel_o    <= '0;
      m_apb_penable_o <= 1'b0;
      m_apb_pwrite_o  <= 1'b0;
      m_apb_pwdata_o  <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if ((write_en_i || read_en_i) && !done_o) begin
            if (onehot_ok(32'(read_write_sel_i))) begin
              m_apb_paddr_o  <= read_write_addr_i;
              m_apb_psel_o   <= read_write_sel_i;
              m_apb_pwrite_o <= write_en_i;
              m_apb_pwdata_o <= write_data_i;
              busy_o         <= 1'b1;
              state          <= SETUP;
            end else begin
              // Bad select is answered locally; the APB bus never sees it.
              err_o       <= 1'b1;
              read_data_o <= '0;
              done_o      <= 1'b1;
              state       <= RESP;
            end
          end
        end
        SETUP: begin
          m_apb_penable_o <= 1'b1;
          state           <= ACCESS;
        end
        ACCESS: begin
          // PREADY takes priority over a timeout expiring in the same cycle.
          if (m_apb_pready_i) begin
            m_apb_psel_o    <= '0;
            m_apb_penable_o <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b1;
            err_o           <= m_apb_pslverr_i;
            read_data_o     <= m_apb_pwrite_o ? '0 : m_apb_prdata_i;
            state           <= RESP;
          end else if (timeout) begin
            m_apb_psel_o    <= '0;
            m_apb_penable_o <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b1;
            err_o           <= 1'b1;
            read_data_o     <= '0;
            state           <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_fsm.sv
// Scoreboard bench for apb_master_fsm with a randomized APB slave model.
// Also exercises the timeout path when built with APB_TIMEOUT_EN.
module tb_apb_master_fsm;

  localparam int TO_LIMIT = 1024;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        busy, done, err;
  logic [31:0] paddr;
  logic [3:0]  psel;
  logic        penable, pwrite;
  logic [31:0] pwdata;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;
  logic        pslverr = 1'b0;

  apb_master_fsm #(.AW(32), .DW(32), .NUM_SLAVES(4)) dut (
    .m_apb_pclk_i      (clk),
    .m_apb_presetn_i   (rst_n),
    .read_write_addr_i (addr),
    .read_write_sel_i  (sel),
    .write_en_i        (we),
    .write_data_i      (wdata),
    .read_en_i         (re),
    .read_data_o       (rdata),
    .busy_o            (busy),
    .done_o            (done),
    .err_o             (err),
    .m_apb_paddr_o     (paddr),
    .m_apb_psel_o      (psel),
    .m_apb_penable_o   (penable),
    .m_apb_pwrite_o    (pwrite),
    .m_apb_pwdata_o    (pwdata),
    .m_apb_pready_i    (pready),
    .m_apb_prdata_i    (prdata),
    .m_apb_pslverr_i   (pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int          t;
    int          lat;
    bit          legal;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  // What the slave should see for the transfer in flight
  bit          apb_active = 1'b0;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_sel;
  logic        exp_write;
  int          cfg_waits = 0;
  logic [31:0] cfg_prdata = '0;
  logic        cfg_slverr = 1'b0;

  // APB slave model: checks phase contents, inserts wait states, returns data
  int acc_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (psel != 4'b0) begin
        chk("apb_activity", 32'(apb_active), 32'd1);
        chk("psel", 32'(psel), 32'(exp_sel));
        chk("paddr", paddr, exp_addr);
        chk("pwrite", 32'(pwrite), 32'(exp_write));
        chk("pwdata", pwdata, exp_wdata);
      end
      if (psel != 4'b0 && penable) begin
        if (acc_cnt == cfg_waits) begin
          pready  = 1'b1;
          prdata  = cfg_prdata;
          pslverr = cfg_slverr;
        end else begin
          pready  = 1'b0;
          prdata  = $urandom;
          pslverr = 1'($urandom);
        end
        acc_cnt++;
      end else begin
        pready  = 1'($urandom);
        prdata  = $urandom;
        pslverr = 1'($urandom);
        acc_cnt = 0;
      end
    end else begin
      acc_cnt = 0;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && cyc > sb[0].t) begin
        int d;
        d = cyc - sb[0].t;
        chk("busy", 32'(busy), 32'(sb[0].legal && d <= sb[0].lat - 1));
        if (done) begin
          chk("latency", 32'(d), 32'(sb[0].lat));
          chk("err", 32'(err), 32'(sb[0].err));
          chk("rdata", rdata, sb[0].rdata);
          void'(sb.pop_front());
        end else if (d > sb[0].lat + 4) begin
          chk("done_missing", 32'd0, 32'd1);
          void'(sb.pop_front());
        end
      end else if (done) begin
        chk("spurious_done", 32'(done), 32'd0);
      end
    end
  end

  task automatic xfer(input logic [31:0] a, input logic [3:0] s, input logic w, input logic r,
                      input logic [31:0] wd, input int waits, input logic [31:0] rd, input logic serr);
    exp_t e;
    int   n;
    bit   got;
    @(negedge clk);
    e.t     = cyc;
    e.legal = ($countones(s) == 1);
    if (!e.legal) begin
      e.err = 1'b1; e.rdata = '0; e.lat = 1;
    end else if (TO_ON && waits >= TO_LIMIT) begin
      e.err = 1'b1; e.rdata = '0; e.lat = 2 + TO_LIMIT;
    end else begin
      e.err = serr; e.rdata = w ? 32'h0 : rd; e.lat = 3 + waits;
    end
    cfg_waits = waits; cfg_prdata = rd; cfg_slverr = serr;
    exp_addr = a; exp_sel = s; exp_write = w; exp_wdata = wd;
    apb_active = e.legal;
    sb.push_back(e);
    addr = a; sel = s; we = w; re = r; wdata = wd;
    got = 1'b0;
    n = 0;
    while (!got && n <= e.lat + 5) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else begin
        // Mid-transfer input churn must not reach the bus
        addr = $urandom; wdata = $urandom; sel = 4'($urandom);
      end
    end
    if (!got) chk("drv_bound", 32'd0, 32'd1);
    we = 1'b0; re = 1'b0;
    chk("psel_released", 32'(psel), 32'd0);
    apb_active = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;

    // Directed cases
    xfer(32'h4, 4'b0010, 1'b1, 1'b0, 32'hA5A5_5AA5, 0, 32'hDEAD_BEEF, 1'b0);
    xfer(32'h8, 4'b0001, 1'b0, 1'b1, 32'h0, 3, 32'h1234_5678, 1'b0);
    xfer(32'hC, 4'b0100, 1'b0, 1'b1, 32'h0, 1, 32'h0BAD_0BAD, 1'b1);
    xfer(32'h10, 4'b0000, 1'b1, 1'b0, 32'h1111_1111, 0, 32'h5555_5555, 1'b0);
    xfer(32'h14, 4'b0110, 1'b0, 1'b1, 32'h0, 0, 32'h6666_6666, 1'b0);
    xfer(32'h18, 4'b1000, 1'b1, 1'b1, 32'hCAFE_F00D, 2, 32'h7777_7777, 1'b0);

    // Randomized traffic with random idle gaps
    for (int i = 0; i < 200; i++) begin
      logic [3:0] s;
      logic [1:0] rw;
      rw = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 3) != 0) s = 4'b0001 << $urandom_range(0, 3);
      else s = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xfer($urandom, s, rw[0], rw[1], $urandom, $urandom_range(0, 4), $urandom, 1'($urandom));
    end

    // Reset in the middle of an ACCESS phase
    @(negedge clk);
    cfg_waits = 50; cfg_prdata = 32'h0; cfg_slverr = 1'b0;
    exp_addr = 32'h20; exp_sel = 4'b0100; exp_write = 1'b0; exp_wdata = 32'h0;
    apb_active = 1'b1;
    addr = 32'h20; sel = 4'b0100; we = 1'b0; re = 1'b1; wdata = 32'h0;
    repeat (4) @(negedge clk);
    chk("pre_rst_penable", 32'(penable), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    re = 1'b0;
    apb_active = 1'b0;
    #1;
    chk("midrst_psel", 32'(psel), 32'd0);
    chk("midrst_penable", 32'(penable), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    chk("inrst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    xfer(32'h24, 4'b0010, 1'b0, 1'b1, 32'h0, 1, 32'h2468_ACE0, 1'b0);

`ifdef APB_TIMEOUT_EN
    xfer(32'h28, 4'b0001, 1'b0, 1'b1, 32'h0, 5000, 32'h1357_9BDF, 1'b0);
    xfer(32'h2C, 4'b1000, 1'b0, 1'b1, 32'h0, TO_LIMIT - 1, 32'h1357_9BDF, 1'b0);
    xfer(32'h30, 4'b0100, 1'b1, 1'b0, 32'h9999_0000, TO_LIMIT - 2, 32'h0, 1'b1);
`endif

    repeat (6) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
